// File: rtl/axi4_stream_pkg.sv
// Shared definitions for the AXI4-Stream datamover scheduler:
// FSM state encoding, status-byte field positions and stream-count derivation.
package axi4_stream_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_WAIT_STS = 2'd2,
    ST_HOLDOFF  = 2'd3
  } sched_state_e;

  // Datamover status byte layout
  localparam int unsigned STS_W          = 8;
  localparam int unsigned STS_OKAY_BIT   = 7;
  localparam int unsigned STS_SLVERR_BIT = 6;
  localparam int unsigned STS_DECERR_BIT = 5;
  localparam int unsigned STS_INTERR_BIT = 4;
  localparam int unsigned STS_TAG_W      = 4;

  // Completed-transfer counter width
  localparam int unsigned DONE_W = 16;

  // Number of streams for a given log2 stream-count width
  function automatic int unsigned num_streams(input int unsigned streams_width);
    return 32'd1 << streams_width;
  endfunction

endpackage

// File: rtl/axi4_stream_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req      - request vector, one bit per stream
//   last_idx - index granted most recently; search starts at last_idx+1
//   grant_c  - first requesting index found (wrapping); last_idx when none
//   valid_c  - at least one request present
module axi4_stream_rr_pick
  import axi4_stream_pkg::*;
#(
  parameter  int unsigned W = 2,
  localparam int unsigned N = num_streams(W)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_idx,
  output logic [W-1:0] grant_c,
  output logic         valid_c
);

  logic [W-1:0] idx;

  // Scan last_idx+1 .. last_idx+N; W-bit addition wraps modulo N
  always_comb begin
    grant_c = last_idx;
    valid_c = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = last_idx + W'(i);
      if (!valid_c && req[idx]) begin
        grant_c = idx;
        valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_stream_scheduler.sv
// Round-robin scheduler issuing one datamover command at a time across
// NUM_STREAMS streams, with status checking, watchdog and completion count.
// Ports:
//   clk, rst_n      - rising-edge clock, async active-low reset
//   stream_pending  - per-stream addr/size FIFOs both non-empty
//   stream_enable   - software enable mask
//   cmd_fire        - datamover command handshake
//   sts_fire        - datamover status handshake
//   sts_data        - status byte {OKAY, SLVERR, DECERR, INTERR, tag[3:0]}
//   timeout_limit   - watchdog limit in cycles, 0 disables
//   err_clear       - pulse clearing err_flags
//   stream_select   - granted stream index
//   stream_valid    - grant qualifier
//   busy            - FSM outside IDLE
//   timeout         - one-cycle pulse on watchdog expiry
//   err_flags       - sticky per-stream error bits
//   done_count      - completed transfers, wrapping
module axi4_stream_scheduler
  import axi4_stream_pkg::*;
#(
  parameter  int unsigned C_STREAMS_WIDTH = 2,
  parameter  int unsigned C_TIMEOUT_WIDTH = 16,
  localparam int unsigned NUM_STREAMS     = num_streams(C_STREAMS_WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_STREAMS-1:0]     stream_pending,
  input  logic [NUM_STREAMS-1:0]     stream_enable,
  input  logic                       cmd_fire,
  input  logic                       sts_fire,
  input  logic [STS_W-1:0]           sts_data,
  input  logic [C_TIMEOUT_WIDTH-1:0] timeout_limit,
  input  logic                       err_clear,
  output logic [C_STREAMS_WIDTH-1:0] stream_select,
  output logic                       stream_valid,
  output logic                       busy,
  output logic                       timeout,
  output logic [NUM_STREAMS-1:0]     err_flags,
  output logic [DONE_W-1:0]          done_count
);

  localparam int unsigned SW = C_STREAMS_WIDTH;
  localparam int unsigned TW = C_TIMEOUT_WIDTH;

  sched_state_e           state_q, state_d;
  logic [SW-1:0]          stream_select_q, stream_select_d;
  logic [SW-1:0]          last_granted_q, last_granted_d;
  logic                   stream_valid_q, stream_valid_d;
  logic                   busy_q, busy_d;
  logic                   timeout_q, timeout_d;
  logic [NUM_STREAMS-1:0] err_flags_q, err_flags_d;
  logic [DONE_W-1:0]      done_count_q, done_count_d;
  logic [TW-1:0]          wd_q, wd_d;

  logic [NUM_STREAMS-1:0] cand_c;
  logic [SW-1:0]          pick_c;
  logic                   pick_valid_c;
  logic                   sel_live_c;
  logic                   sts_bad_c;
  logic [TW-1:0]          wd_inc_c;
  logic                   wd_expire_c;

  assign cand_c = stream_pending & stream_enable;

  axi4_stream_rr_pick #(
    .W (SW)
  ) u_rr_pick (
    .req      (cand_c),
    .last_idx (last_granted_q),
    .grant_c  (pick_c),
    .valid_c  (pick_valid_c)
  );

  // Granted stream is still both pending and enabled
  assign sel_live_c = cand_c[stream_select_q];

  // Status is bad unless OKAY alone is set and the tag echoes the grant
  assign sts_bad_c = !sts_data[STS_OKAY_BIT]   ||
                     sts_data[STS_SLVERR_BIT]  ||
                     sts_data[STS_DECERR_BIT]  ||
                     sts_data[STS_INTERR_BIT]  ||
                     (32'(sts_data[STS_TAG_W-1:0]) != 32'(stream_select_q));

  // Saturating watchdog; expiry compares the count including this cycle
  assign wd_inc_c    = (wd_q == '1) ? wd_q : wd_q + TW'(1);
  assign wd_expire_c = (timeout_limit != '0) && (wd_inc_c == timeout_limit);

  // Next-state and output logic
  always_comb begin
    state_d         = state_q;
    stream_select_d = stream_select_q;
    last_granted_d  = last_granted_q;
    stream_valid_d  = stream_valid_q;
    timeout_d       = 1'b0;
    wd_d            = wd_q;
    done_count_d    = done_count_q;
    // Clear first so a same-cycle error set below wins for its stream
    err_flags_d     = err_clear ? '0 : err_flags_q;

    case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (pick_valid_c) begin
          stream_select_d = pick_c;
          stream_valid_d  = 1'b1;
          state_d         = ST_GRANT;
        end
      end

      ST_GRANT: begin
        wd_d = wd_inc_c;
        if (wd_expire_c) begin
          timeout_d                    = 1'b1;
          err_flags_d[stream_select_q] = 1'b1;
          stream_valid_d               = 1'b0;
          state_d                      = ST_IDLE;
        end else if (cmd_fire) begin
          last_granted_d = stream_select_q;
          stream_valid_d = 1'b0;
          state_d        = ST_WAIT_STS;
        end else if (!sel_live_c) begin
          // Request withdrawn before the command went out: quiet abort
          stream_valid_d = 1'b0;
          state_d        = ST_IDLE;
        end
      end

      ST_WAIT_STS: begin
        wd_d = wd_inc_c;
        if (wd_expire_c) begin
          timeout_d                    = 1'b1;
          err_flags_d[stream_select_q] = 1'b1;
          state_d                      = ST_IDLE;
        end else if (sts_fire) begin
          if (sts_bad_c) begin
            err_flags_d[stream_select_q] = 1'b1;
          end
          done_count_d = done_count_q + DONE_W'(1);
          state_d      = ST_HOLDOFF;
        end
      end

      ST_HOLDOFF: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d        = ST_IDLE;
        stream_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      stream_select_q <= '0;
      last_granted_q  <= SW'(NUM_STREAMS - 1);
      stream_valid_q  <= 1'b0;
      busy_q          <= 1'b0;
      timeout_q       <= 1'b0;
      err_flags_q     <= '0;
      done_count_q    <= '0;
      wd_q            <= '0;
    end else begin
      state_q         <= state_d;
      stream_select_q <= stream_select_d;
      last_granted_q  <= last_granted_d;
      stream_valid_q  <= stream_valid_d;
      busy_q          <= busy_d;
      timeout_q       <= timeout_d;
      err_flags_q     <= err_flags_d;
      done_count_q    <= done_count_d;
      wd_q            <= wd_d;
    end
  end

  assign stream_select = stream_select_q;
  assign stream_valid  = stream_valid_q;
  assign busy          = busy_q;
  assign timeout       = timeout_q;
  assign err_flags     = err_flags_q;
  assign done_count    = done_count_q;

endmodule

// File: tb/tb_axi4_stream_scheduler.sv
// Directed self-checking bench for axi4_stream_scheduler (default parameters).
module tb_axi4_stream_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  stream_pending;
  logic [3:0]  stream_enable;
  logic        cmd_fire;
  logic        sts_fire;
  logic [7:0]  sts_data;
  logic [15:0] timeout_limit;
  logic        err_clear;
  logic [1:0]  stream_select;
  logic        stream_valid;
  logic        busy;
  logic        timeout;
  logic [3:0]  err_flags;
  logic [15:0] done_count;

  int n_checks = 0;
  int n_pass   = 0;

  axi4_stream_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stream_pending (stream_pending),
    .stream_enable  (stream_enable),
    .cmd_fire       (cmd_fire),
    .sts_fire       (sts_fire),
    .sts_data       (sts_data),
    .timeout_limit  (timeout_limit),
    .err_clear      (err_clear),
    .stream_select  (stream_select),
    .stream_valid   (stream_valid),
    .busy           (busy),
    .timeout        (timeout),
    .err_flags      (err_flags),
    .done_count     (done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for a grant
  task automatic wait_grant();
    int n = 0;
    while (!stream_valid && n < 10) begin
      step();
      n++;
    end
    chk("grant_seen", 32'(stream_valid), 32'd1);
  endtask

  // One full transfer: grant, command after 2 cycles, status after 2 cycles
  task automatic do_xfer(input logic [1:0] exp_sel, input logic [7:0] sts,
                         input logic [3:0] nxt_pend, input logic clr,
                         input logic [15:0] exp_done, input logic [3:0] exp_err);
    wait_grant();
    chk("grant_sel", 32'(stream_select), 32'(exp_sel));
    step();
    step();
    chk("grant_hold", 32'({stream_valid, stream_select}), 32'({1'b1, exp_sel}));
    cmd_fire       = 1'b1;
    stream_pending = nxt_pend;
    step();
    cmd_fire = 1'b0;
    chk("cmd_accept", 32'({busy, stream_valid}), 32'b10);
    step();
    step();
    sts_data  = sts;
    sts_fire  = 1'b1;
    err_clear = clr;
    step();
    sts_fire  = 1'b0;
    err_clear = 1'b0;
    chk("sts_done", 32'(done_count), 32'(exp_done));
    chk("sts_err", 32'(err_flags), 32'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL bench_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b1;
    stream_pending = 4'b0000;
    stream_enable  = 4'b0000;
    cmd_fire       = 1'b0;
    sts_fire       = 1'b0;
    sts_data       = 8'h00;
    timeout_limit  = 16'd0;
    err_clear      = 1'b0;
    #3;
    rst_n = 1'b0;
    step();
    step();
    chk("rst_outputs", 32'({stream_select, stream_valid, busy, timeout, err_flags}), 32'd0);
    chk("rst_done", 32'(done_count), 32'd0);

    // All streams pending: strict rotation starting at stream 0
    stream_pending = 4'b1111;
    stream_enable  = 4'b1111;
    rst_n          = 1'b1;
    do_xfer(2'd0, 8'h80, 4'b1111, 1'b0, 16'd1, 4'b0000);
    do_xfer(2'd1, 8'h81, 4'b1111, 1'b0, 16'd2, 4'b0000);
    do_xfer(2'd2, 8'h82, 4'b1111, 1'b0, 16'd3, 4'b0000);
    do_xfer(2'd3, 8'h83, 4'b1111, 1'b0, 16'd4, 4'b0000);
    do_xfer(2'd0, 8'h80, 4'b0000, 1'b0, 16'd5, 4'b0000);

    // Single pending stream: one-cycle pick latency, SLVERR sets its flag
    step();
    chk("idle_empty", 32'({stream_valid, busy}), 32'b00);
    stream_pending = 4'b0100;
    step();
    chk("pick_latency", 32'({stream_valid, stream_select}), 32'({1'b1, 2'd2}));
    do_xfer(2'd2, 8'hC2, 4'b0000, 1'b0, 16'd6, 4'b0100);

    // Clear errors, then stray handshakes in IDLE are ignored
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("err_clear", 32'(err_flags), 32'd0);
    cmd_fire = 1'b1;
    sts_fire = 1'b1;
    sts_data = 8'h00;
    step();
    cmd_fire = 1'b0;
    sts_fire = 1'b0;
    chk("stray_fire", 32'({busy, err_flags, done_count}), 32'({1'b0, 4'b0000, 16'd6}));

    // Watchdog: 10 cycles in GRANT without a command
    timeout_limit  = 16'd10;
    stream_pending = 4'b0010;
    step();
    chk("wd_grant", 32'({stream_valid, stream_select}), 32'({1'b1, 2'd1}));
    repeat (9) step();
    chk("wd_before", 32'({timeout, stream_valid}), 32'b01);
    step();
    chk("wd_pulse", 32'({timeout, stream_valid, busy}), 32'b100);
    chk("wd_err", 32'(err_flags), 32'b0010);
    chk("wd_done", 32'(done_count), 32'd6);
    stream_pending = 4'b0000;
    timeout_limit  = 16'd0;
    step();
    chk("wd_one_shot", 32'({timeout, busy}), 32'b00);

    // Enable dropped during GRANT: quiet abort, round-robin pointer unchanged
    stream_pending = 4'b1000;
    step();
    chk("drop_grant", 32'({stream_valid, stream_select}), 32'({1'b1, 2'd3}));
    stream_enable = 4'b0111;
    step();
    chk("drop_abort", 32'({stream_valid, busy}), 32'b00);
    chk("drop_noerr", 32'(err_flags), 32'b0010);
    stream_pending = 4'b1001;
    do_xfer(2'd0, 8'h80, 4'b0000, 1'b0, 16'd7, 4'b0010);

    // All streams disabled: no grants
    stream_enable  = 4'b0000;
    stream_pending = 4'b1111;
    repeat (4) step();
    chk("all_disabled", 32'({stream_valid, busy}), 32'b00);

    // Tag mismatch, then a new error coincident with err_clear
    stream_enable  = 4'b1111;
    stream_pending = 4'b0100;
    do_xfer(2'd2, 8'h81, 4'b0100, 1'b0, 16'd8, 4'b0110);
    do_xfer(2'd2, 8'h81, 4'b0000, 1'b1, 16'd9, 4'b0100);

    // Asynchronous reset while waiting for status
    stream_pending = 4'b1111;
    wait_grant();
    chk("pre_rst_sel", 32'(stream_select), 32'd3);
    cmd_fire = 1'b1;
    step();
    cmd_fire = 1'b0;
    step();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst", 32'({stream_select, stream_valid, busy, timeout, err_flags}), 32'd0);
    chk("async_rst_done", 32'(done_count), 32'd0);
    step();
    rst_n = 1'b1;
    wait_grant();
    chk("post_rst_sel", 32'(stream_select), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
